bram_stream_loader: RTL

- AXI-Stream slave that receives one frame of lattice populations and writes it into the nine per-direction BRAMs of the LBM solver.
- Each beat carries one pixel: 144 bits, nine 16-bit directions.
- It is the write side of the BRAM read-out path: it accepts the same beat format and frame length that the read-out streamer produces, and loads the BRAMs the solver iterates on.

---
 rtl/bram_stream_loader_if.sv | 27 ++
 rtl/bram_stream_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader_if.sv
// AXI-Stream pixel beat bundle between a population source and the BRAM loader.
// One beat carries nine direction lanes, packed {null, n, ne, e, se, s, sw, w, nw}.
interface bram_stream_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [9*DATA_WIDTH-1:0]   tdata;
  logic [9*DATA_WIDTH/8-1:0] tstrb;
  logic                      tvalid;
  logic                      tlast;
  logic                      tready;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/bram_stream_loader.sv
// Receives one frame of lattice populations over AXI-Stream and writes it into
// the nine per-direction BRAMs of the LBM solver, one pixel per beat.
// The write port is registered: an accepted beat appears on wr_* one cycle later,
// so the last write of a frame lines up with the frame_loaded pulse.
module bram_stream_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  bram_stream_loader_if.slave      s00_axis,
  input  logic                     load_enable,
  input  logic                     err_clear,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_null,
  output logic [DATA_WIDTH-1:0]    wr_n,
  output logic [DATA_WIDTH-1:0]    wr_ne,
  output logic [DATA_WIDTH-1:0]    wr_e,
  output logic [DATA_WIDTH-1:0]    wr_se,
  output logic [DATA_WIDTH-1:0]    wr_s,
  output logic [DATA_WIDTH-1:0]    wr_sw,
  output logic [DATA_WIDTH-1:0]    wr_w,
  output logic [DATA_WIDTH-1:0]    wr_nw,
  output logic                     loading,
  output logic                     frame_loaded,
  output logic                     err_early_last,
  output logic                     err_missing_last
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                         r_state;
  logic [ADDRESS_WIDTH-1:0]       r_count;
  logic                           r_tready;
  logic                           r_wr_en;
  logic [ADDRESS_WIDTH-1:0]       r_wr_addr;
  logic [8:0][DATA_WIDTH-1:0]     r_lanes;
  logic                           r_loading;
  logic                           r_frame_loaded;
  logic                           r_err_early_last;
  logic                           r_err_missing_last;

  logic                           w_accept;
  logic                           w_unused;

  // Partial strobes are not supported, so tstrb is deliberately left unused.
  assign w_unused = ^s00_axis.tstrb;
  assign w_accept = s00_axis.tvalid && r_tready;

  // Frame FSM, beat counter, registered BRAM write port and sticky error flags.
  // Error clears are applied first so a same-cycle error event overrides them.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_state            <= IDLE;
      r_count            <= '0;
      r_tready           <= 1'b0;
      r_wr_en            <= 1'b0;
      r_wr_addr          <= '0;
      r_lanes            <= '0;
      r_loading          <= 1'b0;
      r_frame_loaded     <= 1'b0;
      r_err_early_last   <= 1'b0;
      r_err_missing_last <= 1'b0;
    end else begin
      r_wr_en        <= 1'b0;
      r_frame_loaded <= 1'b0;
      if (err_clear) begin
        r_err_early_last   <= 1'b0;
        r_err_missing_last <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (load_enable) begin
            r_state   <= RECEIVE;
            r_count   <= '0;
            r_tready  <= 1'b1;
            r_loading <= 1'b1;
          end
        end
        RECEIVE: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_count;
            r_lanes   <= s00_axis.tdata;
            if (r_count == LAST_ADDR) begin
              r_state        <= DONE;
              r_tready       <= 1'b0;
              r_loading      <= 1'b0;
              r_frame_loaded <= 1'b1;
              if (!s00_axis.tlast) begin
                r_err_missing_last <= 1'b1;
              end
            end else if (s00_axis.tlast) begin
              r_state          <= IDLE;
              r_tready         <= 1'b0;
              r_loading        <= 1'b0;
              r_err_early_last <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_tready  <= 1'b0;
          r_loading <= 1'b0;
        end
      endcase
    end
  end

  assign s00_axis.tready  = r_tready;
  assign wr_en            = r_wr_en;
  assign wr_addr          = r_wr_addr;
  assign wr_nw            = r_lanes[0];
  assign wr_w             = r_lanes[1];
  assign wr_sw            = r_lanes[2];
  assign wr_s             = r_lanes[3];
  assign wr_se            = r_lanes[4];
  assign wr_e             = r_lanes[5];
  assign wr_ne            = r_lanes[6];
  assign wr_n             = r_lanes[7];
  assign wr_null          = r_lanes[8];
  assign loading          = r_loading;
  assign frame_loaded     = r_frame_loaded;
  assign err_early_last   = r_err_early_last;
  assign err_missing_last = r_err_missing_last;

endmodule
